// File: rtl/pn_ctrl_pkg.sv
// rtl/pn_ctrl_pkg.sv - shared widths, FSM and grant encodings for the synapse port arbiter
package pn_ctrl_pkg;

    localparam int AW = 7;
    localparam int DW = 32;

    typedef enum logic {
        IDLE,
        SPK_B
    } fsm_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_CFG,
        G_SWU,
        G_SPK
    } grant_t;

    // SWU weights are 8-bit; the synapse word is zero-extended
    function automatic logic [DW-1:0] swu_word(input logic [7:0] w);
        return {{(DW-8){1'b0}}, w};
    endfunction

endpackage

// File: rtl/syn_port_arbiter_if.sv
// rtl/syn_port_arbiter_if.sv - requester and synapse-port bundle for the arbiter
interface syn_port_arbiter_if;

    logic                           cfg_valid;
    logic                           cfg_ready;
    logic [pn_ctrl_pkg::AW-1:0]     cfg_addr;
    logic [pn_ctrl_pkg::DW-1:0]     cfg_data;

    logic                           swu_en;
    logic [pn_ctrl_pkg::AW-1:0]     swu_addr;
    logic [7:0]                     swu_data;
    logic                           swu_full;
    logic                           swu_ovf;

    logic                           spk_valid;
    logic                           spk_ready;
    logic [2*pn_ctrl_pkg::AW-1:0]   spk_addr;

    logic                           syn_we;
    logic                           syn_re;
    logic [pn_ctrl_pkg::AW-1:0]     syn_addr;
    logic [pn_ctrl_pkg::DW-1:0]     syn_wdata;

    modport master (
        output cfg_valid, cfg_addr, cfg_data,
        output swu_en, swu_addr, swu_data,
        output spk_valid, spk_addr,
        input  cfg_ready, swu_full, swu_ovf, spk_ready,
        input  syn_we, syn_re, syn_addr, syn_wdata
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data,
        input  swu_en, swu_addr, swu_data,
        input  spk_valid, spk_addr,
        output cfg_ready, swu_full, swu_ovf, spk_ready,
        output syn_we, syn_re, syn_addr, syn_wdata
    );

endinterface

// File: rtl/syn_swu_fifo.sv
// rtl/syn_swu_fifo.sv - small synchronous FIFO buffering SWU address/weight pairs
module syn_swu_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_nxt;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // full/empty are registered from the next count so the caller sees clean flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/syn_port_arbiter.sv
// rtl/syn_port_arbiter.sv - shares the synapse port between cfg writes, SWU writes and spike reads
module syn_port_arbiter
    import pn_ctrl_pkg::*;
#(
    parameter int SWU_DEPTH = 4,
    parameter int MAX_WAIT  = 8
) (
    input  logic               clk,
    input  logic               rst,
    syn_port_arbiter_if.slave  bus
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    fsm_t          state;
    grant_t        grant;
    logic [AW-1:0] b_addr;
    logic [WW-1:0] wait_cnt;
    logic          rr_swu;
    logic          forced;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW+7:0] fifo_rdata;

    assign forced = bus.cfg_valid && (wait_cnt == WAIT_MAX);

    always_comb begin
        grant = G_NONE;
        if (state == IDLE) begin
            if (forced) begin
                grant = G_CFG;
            end else if (bus.spk_valid) begin
                grant = G_SPK;
            end else if (!fifo_empty && bus.cfg_valid) begin
                grant = rr_swu ? G_SWU : G_CFG;
            end else if (!fifo_empty) begin
                grant = G_SWU;
            end else if (bus.cfg_valid) begin
                grant = G_CFG;
            end
        end
    end

    assign bus.cfg_ready = (grant == G_CFG);
    assign bus.spk_ready = (grant == G_SPK);
    assign pop           = (grant == G_SWU);
    // a full FIFO can still take a push when the same cycle frees a slot
    assign push          = bus.swu_en && (!fifo_full || pop);
    assign bus.swu_full  = fifo_full;

    syn_swu_fifo #(
        .W     (AW + 8),
        .DEPTH (SWU_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.swu_addr, bus.swu_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            b_addr        <= '0;
            wait_cnt      <= '0;
            rr_swu        <= 1'b1;
            bus.swu_ovf   <= 1'b0;
            bus.syn_we    <= 1'b0;
            bus.syn_re    <= 1'b0;
            bus.syn_addr  <= '0;
            bus.syn_wdata <= '0;
        end else begin
            bus.syn_we    <= 1'b0;
            bus.syn_re    <= 1'b0;
            bus.syn_addr  <= '0;
            bus.syn_wdata <= '0;

            if (bus.swu_en && fifo_full && !pop) begin
                bus.swu_ovf <= 1'b1;
            end

            if (!bus.cfg_valid || bus.cfg_ready) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (grant == G_CFG) begin
                rr_swu <= 1'b1;
            end else if (grant == G_SWU) begin
                rr_swu <= 1'b0;
            end

            case (state)
                IDLE: begin
                    case (grant)
                        G_CFG: begin
                            bus.syn_we    <= 1'b1;
                            bus.syn_addr  <= bus.cfg_addr;
                            bus.syn_wdata <= bus.cfg_data;
                        end
                        G_SWU: begin
                            bus.syn_we    <= 1'b1;
                            bus.syn_addr  <= fifo_rdata[AW+7:8];
                            bus.syn_wdata <= swu_word(fifo_rdata[7:0]);
                        end
                        G_SPK: begin
                            bus.syn_re   <= 1'b1;
                            bus.syn_addr <= bus.spk_addr[AW-1:0];
                            // neuron B of 0 means a single-neuron spike
                            if (bus.spk_addr[2*AW-1:AW] != '0) begin
                                b_addr <= bus.spk_addr[2*AW-1:AW];
                                state  <= SPK_B;
                            end
                        end
                        default: ;
                    endcase
                end
                SPK_B: begin
                    bus.syn_re   <= 1'b1;
                    bus.syn_addr <= b_addr;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syn_port_arbiter.sv
// tb/tb_syn_port_arbiter.sv - scoreboard bench for syn_port_arbiter
module tb_syn_port_arbiter;

    typedef struct packed {
        logic        we;
        logic        re;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } op_t;

    logic clk;
    logic rst;
    logic mon_en;
    int   total;
    int   bad;
    int   got;
    op_t  exp_q [$];

    syn_port_arbiter_if bus();

    syn_port_arbiter #(
        .SWU_DEPTH (4),
        .MAX_WAIT  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic op_t mk(input logic we, input logic re, input logic [6:0] a, input logic [31:0] d);
        op_t o;
        o.we    = we;
        o.re    = re;
        o.addr  = a;
        o.wdata = d;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && (bus.syn_we === 1'b1 || bus.syn_re === 1'b1)) begin
            op_t act;
            op_t e;
            act = mk(bus.syn_we, bus.syn_re, bus.syn_addr, bus.syn_wdata);
            check("one_op_per_cycle", 64'(bus.syn_we & bus.syn_re), 64'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_op: got we=%0b re=%0b addr=%0h wdata=%0h want none",
                         act.we, act.re, act.addr, act.wdata);
            end else begin
                e = exp_q.pop_front();
                check("syn_op", 64'(act), 64'(e));
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        mon_en = 1'b0;
        rst = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.swu_en = 1'b0;    bus.swu_addr = '0; bus.swu_data = '0;
        bus.spk_valid = 1'b0; bus.spk_addr = '0;
        step();
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        check("rst_syn_we", 64'(bus.syn_we), 64'd0);
        check("rst_syn_re", 64'(bus.syn_re), 64'd0);
        check("rst_syn_addr", 64'(bus.syn_addr), 64'd0);
        check("rst_syn_wdata", 64'(bus.syn_wdata), 64'd0);
        check("rst_swu_full", 64'(bus.swu_full), 64'd0);
        check("rst_swu_ovf", 64'(bus.swu_ovf), 64'd0);
        check("rst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
        check("rst_spk_ready", 64'(bus.spk_ready), 64'd0);
        step();

        // single-neuron spike, then another spike proves FSM stayed IDLE
        bus.spk_valid = 1'b1; bus.spk_addr = {7'd0, 7'd5};
        #1;
        check("t1_spk_ready", 64'(bus.spk_ready), 64'd1);
        exp_q.push_back(mk(1'b0, 1'b1, 7'd5, 32'd0));
        step();
        bus.spk_addr = {7'd0, 7'd6};
        #1;
        check("t1_still_idle", 64'(bus.spk_ready), 64'd1);
        exp_q.push_back(mk(1'b0, 1'b1, 7'd6, 32'd0));
        step();
        bus.spk_valid = 1'b0;
        step();

        // two-neuron spike with a cfg write waiting behind it
        bus.spk_valid = 1'b1; bus.spk_addr = {7'd9, 7'd3};
        bus.cfg_valid = 1'b1; bus.cfg_addr = 7'h20; bus.cfg_data = 32'hDEADBEEF;
        #1;
        check("t2_spk_ready", 64'(bus.spk_ready), 64'd1);
        check("t2_cfg_blocked_a", 64'(bus.cfg_ready), 64'd0);
        exp_q.push_back(mk(1'b0, 1'b1, 7'd3, 32'd0));
        exp_q.push_back(mk(1'b0, 1'b1, 7'd9, 32'd0));
        step();
        bus.spk_valid = 1'b0;
        #1;
        check("t2_cfg_blocked_b", 64'(bus.cfg_ready), 64'd0);
        step();
        #1;
        check("t2_cfg_after_b", 64'(bus.cfg_ready), 64'd1);
        exp_q.push_back(mk(1'b1, 1'b0, 7'h20, 32'hDEADBEEF));
        step();
        bus.cfg_valid = 1'b0;
        step();

        // fill the SWU FIFO while spikes hold off every pop
        for (int i = 0; i < 5; i++) begin
            bus.spk_valid = 1'b1; bus.spk_addr = {7'd0, 7'(10 + i)};
            bus.swu_en = 1'b1; bus.swu_addr = 7'(i + 1); bus.swu_data = 8'(8'hA1 + i);
            #1;
            check("t3_spk_ready", 64'(bus.spk_ready), 64'd1);
            exp_q.push_back(mk(1'b0, 1'b1, 7'(10 + i), 32'd0));
            if (i == 4) begin
                check("t3_full_at_5th", 64'(bus.swu_full), 64'd1);
                check("t3_ovf_before_drop", 64'(bus.swu_ovf), 64'd0);
            end
            step();
        end
        bus.spk_valid = 1'b0; bus.swu_en = 1'b0;
        #1;
        check("t3_ovf_set", 64'(bus.swu_ovf), 64'd1);
        check("t3_full_held", 64'(bus.swu_full), 64'd1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(1'b1, 1'b0, 7'(i + 1), 32'(8'hA1 + i)));
        end
        repeat (6) step();
        check("t3_full_drained", 64'(bus.swu_full), 64'd0);
        check("t3_ovf_sticky", 64'(bus.swu_ovf), 64'd1);

        // round-robin between FIFO and cfg from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t4_ovf_cleared", 64'(bus.swu_ovf), 64'd0);
        for (int i = 0; i < 2; i++) begin
            bus.spk_valid = 1'b1; bus.spk_addr = {7'd0, 7'(20 + i)};
            bus.swu_en = 1'b1; bus.swu_addr = 7'(8'h11 + i); bus.swu_data = 8'(8'h51 + i);
            exp_q.push_back(mk(1'b0, 1'b1, 7'(20 + i), 32'd0));
            step();
        end
        bus.spk_valid = 1'b0; bus.swu_en = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_addr = 7'h30; bus.cfg_data = 32'h11111111;
        #1;
        check("t4_g0_swu", 64'(bus.cfg_ready), 64'd0);
        exp_q.push_back(mk(1'b1, 1'b0, 7'h11, 32'h51));
        step();
        check("t4_g1_cfg", 64'(bus.cfg_ready), 64'd1);
        exp_q.push_back(mk(1'b1, 1'b0, 7'h30, 32'h11111111));
        step();
        bus.cfg_addr = 7'h31; bus.cfg_data = 32'h22222222;
        #1;
        check("t4_g2_swu", 64'(bus.cfg_ready), 64'd0);
        exp_q.push_back(mk(1'b1, 1'b0, 7'h12, 32'h52));
        step();
        check("t4_g3_cfg", 64'(bus.cfg_ready), 64'd1);
        exp_q.push_back(mk(1'b1, 1'b0, 7'h31, 32'h22222222));
        step();
        bus.cfg_valid = 1'b0;
        repeat (2) step();

        // starvation guard: cfg must win against a continuous spike stream
        bus.cfg_valid = 1'b1; bus.cfg_addr = 7'h40; bus.cfg_data = 32'hCAFEF00D;
        got = -1;
        for (int i = 0; i < 12 && got < 0; i++) begin
            bus.spk_valid = 1'b1; bus.spk_addr = {7'd0, 7'(30 + i)};
            #1;
            if (bus.cfg_ready) begin
                got = i;
                exp_q.push_back(mk(1'b1, 1'b0, 7'h40, 32'hCAFEF00D));
            end else if (bus.spk_ready) begin
                exp_q.push_back(mk(1'b0, 1'b1, 7'(30 + i), 32'd0));
            end
            step();
        end
        bus.cfg_valid = 1'b0; bus.spk_valid = 1'b0;
        check("t5_forced_grant_cycle", 64'(got), 64'd8);
        repeat (2) step();

        // reset while SPK_B is pending with two FIFO entries
        for (int i = 0; i < 2; i++) begin
            bus.spk_valid = 1'b1; bus.spk_addr = {7'd0, 7'(40 + i)};
            bus.swu_en = 1'b1; bus.swu_addr = 7'(8'h21 + i); bus.swu_data = 8'(8'h61 + i);
            exp_q.push_back(mk(1'b0, 1'b1, 7'(40 + i), 32'd0));
            step();
        end
        bus.swu_en = 1'b0;
        bus.spk_addr = {7'd50, 7'd42};
        #1;
        check("t6_spk_ready", 64'(bus.spk_ready), 64'd1);
        exp_q.push_back(mk(1'b0, 1'b1, 7'd42, 32'd0));
        step();
        bus.spk_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t6_syn_we", 64'(bus.syn_we), 64'd0);
        check("t6_syn_re", 64'(bus.syn_re), 64'd0);
        check("t6_syn_addr", 64'(bus.syn_addr), 64'd0);
        check("t6_syn_wdata", 64'(bus.syn_wdata), 64'd0);
        check("t6_swu_full", 64'(bus.swu_full), 64'd0);
        check("t6_swu_ovf", 64'(bus.swu_ovf), 64'd0);
        repeat (5) step();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
